// File: rtl/cpu_pkg.sv
// Shared types for the CPU core slice: register-pair selects, 16-bit load/stack
// opcode classes and the sequencer state encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    RR_BC = 2'd0,
    RR_DE = 2'd1,
    RR_HL = 2'd2,
    RR_AF = 2'd3
  } rr_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_LO    = 3'd1,
    ST_RD_HI    = 3'd2,
    ST_WR_LO    = 3'd3,
    ST_WR_HI    = 3'd4,
    ST_INTERNAL = 3'd5,
    ST_FINISH   = 3'd6
  } ld16_state_t;

  typedef enum logic [2:0] {
    OP_ILLEGAL   = 3'd0,
    OP_LD_RR_D16 = 3'd1,
    OP_LD_A16_SP = 3'd2,
    OP_PUSH      = 3'd3,
    OP_POP       = 3'd4,
    OP_LD_SP_HL  = 3'd5
  } ld16_op_t;

  typedef struct packed {
    ld16_state_t state;
    logic [1:0]  m_idx;
    logic        t_first;
  } ld16_dbg_t;

  localparam logic [7:0] OPC_LD_A16_SP = 8'h08;
  localparam logic [7:0] OPC_LD_SP_HL  = 8'hF9;
  // Row opcodes: pair index lives in [5:4], the class in [7:6] and [3:0].
  localparam logic [3:0] OPC_LO_LD_RR  = 4'h1;
  localparam logic [3:0] OPC_LO_PUSH   = 4'h5;
  localparam logic [3:0] OPC_LO_POP    = 4'h1;

  function automatic ld16_op_t ld16_decode(input logic [7:0] opc);
    ld16_op_t op;
    op = OP_ILLEGAL;
    if (opc == OPC_LD_A16_SP) op = OP_LD_A16_SP;
    else if (opc == OPC_LD_SP_HL) op = OP_LD_SP_HL;
    else if (opc[7:6] == 2'b00 && opc[3:0] == OPC_LO_LD_RR) op = OP_LD_RR_D16;
    else if (opc[7:6] == 2'b11 && opc[3:0] == OPC_LO_PUSH) op = OP_PUSH;
    else if (opc[7:6] == 2'b11 && opc[3:0] == OPC_LO_POP) op = OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/cpu_mcycle_timer.sv
// T-state counter inside an M-cycle plus a running M-cycle index.
// i_start restarts both at T0; the counter only advances while i_run is high.
module cpu_mcycle_timer #(
  parameter int T_PER_M = 4,
  parameter int M_W     = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_run,
  output logic           o_t_first,
  output logic           o_t_last,
  output logic [M_W-1:0] o_m_idx
);

  localparam int TW = $clog2(T_PER_M);
  localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);

  logic [TW-1:0]  t_q, t_d;
  logic [M_W-1:0] m_q, m_d;

  always_comb begin
    t_d = t_q;
    m_d = m_q;
    if (i_start) begin
      t_d = '0;
      m_d = '0;
    end else if (i_run) begin
      if (t_q == T_LAST) begin
        t_d = '0;
        m_d = m_q + 1'b1;
      end else begin
        t_d = t_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      t_q <= '0;
      m_q <= '0;
    end else begin
      t_q <= t_d;
      m_q <= m_d;
    end
  end

  assign o_t_first = (t_q == '0);
  assign o_t_last  = (t_q == T_LAST);
  assign o_m_idx   = m_q;

endmodule

// File: rtl/cpu_ld16_unit.sv
// SM83 16-bit load/stack sequencer: LD rr,d16 / LD (a16),SP / PUSH / POP / LD SP,HL.
// Owns SP, fetches its immediates at PC and drives the bus and the pair write port.
module cpu_ld16_unit
  import cpu_pkg::*;
#(
  parameter int          T_PER_M  = 4,
  parameter logic [15:0] SP_RESET = 16'hFFFE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_opcode,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_illegal,
  input  logic [15:0] i_pc,
  output logic        o_pc_inc,
  output logic [1:0]  o_rr_sel,
  input  logic [15:0] i_rr_data,
  output logic        o_rr_wr_en,
  output logic [15:0] o_rr_wr_data,
  output logic [15:0] o_sp,
  output logic [15:0] o_mem_rd_addr,
  input  logic [7:0]  i_mem_rd_data,
  output logic        o_mem_wr_en,
  output logic [15:0] o_mem_wr_addr,
  output logic [7:0]  o_mem_wr_data,
  output ld16_dbg_t   o_dbg
);

  ld16_state_t state_q;
  ld16_op_t    op_q;
  rr_sel_t     rr_q;
  logic [15:0] sp_q;
  logic [7:0]  lo_q, hi_q;

  logic        busy, accept, t_first, t_last;
  logic [1:0]  m_idx;
  ld16_op_t    op_dec;
  ld16_state_t first_st;
  rr_sel_t     rr_dec;

  assign busy   = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign accept = i_start && !busy;

  cpu_mcycle_timer #(.T_PER_M(T_PER_M), .M_W(2)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (accept),
    .i_run     (busy),
    .o_t_first (t_first),
    .o_t_last  (t_last),
    .o_m_idx   (m_idx)
  );

  always_comb begin
    op_dec   = ld16_decode(i_opcode);
    first_st = ST_FINISH;
    rr_dec   = RR_BC;
    case (op_dec)
      OP_LD_RR_D16: begin first_st = ST_RD_LO;    rr_dec = rr_sel_t'(i_opcode[5:4]); end
      OP_LD_A16_SP: begin first_st = ST_RD_LO;    rr_dec = RR_BC;                    end
      OP_PUSH:      begin first_st = ST_INTERNAL; rr_dec = rr_sel_t'(i_opcode[5:4]); end
      OP_POP:       begin first_st = ST_RD_LO;    rr_dec = rr_sel_t'(i_opcode[5:4]); end
      OP_LD_SP_HL:  begin first_st = ST_INTERNAL; rr_dec = RR_HL;                    end
      default:      begin first_st = ST_FINISH;   rr_dec = RR_BC;                    end
    endcase
  end

  // Sequencer: every data/SP side effect lands on the last T-state edge of its M-cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ILLEGAL;
      rr_q    <= RR_BC;
      sp_q    <= SP_RESET;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FINISH: begin
          if (accept) begin
            state_q <= first_st;
            op_q    <= op_dec;
            rr_q    <= rr_dec;
          end else begin
            state_q <= ST_IDLE;
            rr_q    <= RR_BC;
          end
        end
        ST_RD_LO: if (t_last) begin
          lo_q    <= i_mem_rd_data;
          state_q <= ST_RD_HI;
          if (op_q == OP_POP) sp_q <= sp_q + 16'd1;
        end
        ST_RD_HI: if (t_last) begin
          hi_q    <= i_mem_rd_data;
          state_q <= (op_q == OP_LD_A16_SP) ? ST_WR_LO : ST_FINISH;
          if (op_q == OP_POP) sp_q <= sp_q + 16'd1;
          if (op_q == OP_LD_RR_D16 && rr_q == RR_AF) sp_q <= {i_mem_rd_data, lo_q};
        end
        ST_WR_LO: if (t_last) begin
          state_q <= (op_q == OP_PUSH) ? ST_FINISH : ST_WR_HI;
        end
        ST_WR_HI: if (t_last) begin
          state_q <= (op_q == OP_PUSH) ? ST_WR_LO : ST_FINISH;
          if (op_q == OP_PUSH) sp_q <= sp_q - 16'd1;
        end
        ST_INTERNAL: if (t_last) begin
          state_q <= (op_q == OP_PUSH) ? ST_WR_HI : ST_FINISH;
          if (op_q == OP_PUSH) sp_q <= sp_q - 16'd1;
          if (op_q == OP_LD_SP_HL) sp_q <= i_rr_data;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus and pair-port drive decoded from registered state only.
  always_comb begin
    o_pc_inc      = 1'b0;
    o_mem_rd_addr = '0;
    o_mem_wr_en   = 1'b0;
    o_mem_wr_addr = '0;
    o_mem_wr_data = '0;
    o_rr_wr_en    = 1'b0;
    o_rr_wr_data  = '0;
    case (state_q)
      ST_RD_LO, ST_RD_HI: begin
        if (op_q == OP_POP) begin
          o_mem_rd_addr = sp_q;
        end else begin
          o_mem_rd_addr = i_pc;
          o_pc_inc      = t_last;
        end
      end
      ST_WR_LO: begin
        o_mem_wr_en = t_last;
        if (op_q == OP_PUSH) begin
          o_mem_wr_addr = sp_q;
          o_mem_wr_data = i_rr_data[7:0];
        end else begin
          o_mem_wr_addr = {hi_q, lo_q};
          o_mem_wr_data = sp_q[7:0];
        end
      end
      ST_WR_HI: begin
        o_mem_wr_en = t_last;
        if (op_q == OP_PUSH) begin
          o_mem_wr_addr = sp_q;
          o_mem_wr_data = i_rr_data[15:8];
        end else begin
          o_mem_wr_addr = {hi_q, lo_q} + 16'd1;
          o_mem_wr_data = sp_q[15:8];
        end
      end
      ST_FINISH: begin
        if (op_q == OP_POP) begin
          o_rr_wr_en   = 1'b1;
          o_rr_wr_data = {hi_q, (rr_q == RR_AF) ? {lo_q[7:4], 4'h0} : lo_q};
        end else if (op_q == OP_LD_RR_D16 && rr_q != RR_AF) begin
          o_rr_wr_en   = 1'b1;
          o_rr_wr_data = {hi_q, lo_q};
        end
      end
      default: ;
    endcase
  end

  assign o_busy    = busy;
  assign o_done    = (state_q == ST_FINISH);
  assign o_illegal = (state_q == ST_FINISH) && (op_q == OP_ILLEGAL);
  assign o_rr_sel  = rr_q;
  assign o_sp      = sp_q;
  assign o_dbg     = '{state: state_q, m_idx: m_idx, t_first: t_first};

endmodule

// File: tb/tb_cpu_ld16_unit.sv
// Directed bench for cpu_ld16_unit: memory/register-file/PC models around the DUT,
// a write scoreboard fed by the stimulus, and a second instance at two T-states per M-cycle.
module tb_cpu_ld16_unit;
  import cpu_pkg::*;

  localparam int T = 4;
  localparam int W = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, start2;
  logic [7:0]  opcode, opcode2;
  logic        busy, done, illegal, pc_inc, rr_wr_en, mem_wr_en;
  logic [1:0]  rr_sel;
  logic [15:0] rr_rd_data, rr_wr_data, sp, mem_rd_addr, mem_wr_addr;
  logic [7:0]  mem_rd_data, mem_wr_data;
  ld16_dbg_t   dbg;
  logic        busy2, done2, illegal2, pc_inc2, rr_wr_en2, mem_wr_en2;
  logic [1:0]  rr_sel2;
  logic [15:0] rr_wr_data2, sp2, mem_rd_addr2, mem_wr_addr2;
  logic [7:0]  mem_rd_data2, mem_wr_data2;
  ld16_dbg_t   dbg2;

  logic [7:0]  mem [0:65535];
  logic [15:0] rf [0:3];
  logic [15:0] pc, pc2;
  logic        ld_mem, ld_rf, ld_pc;
  logic [15:0] ld_addr, ld_val;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  cpu_ld16_unit #(.T_PER_M(T), .SP_RESET(16'hFFFE)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_opcode(opcode),
    .o_busy(busy), .o_done(done), .o_illegal(illegal),
    .i_pc(pc), .o_pc_inc(pc_inc),
    .o_rr_sel(rr_sel), .i_rr_data(rr_rd_data), .o_rr_wr_en(rr_wr_en), .o_rr_wr_data(rr_wr_data),
    .o_sp(sp), .o_mem_rd_addr(mem_rd_addr), .i_mem_rd_data(mem_rd_data),
    .o_mem_wr_en(mem_wr_en), .o_mem_wr_addr(mem_wr_addr), .o_mem_wr_data(mem_wr_data),
    .o_dbg(dbg)
  );

  cpu_ld16_unit #(.T_PER_M(2), .SP_RESET(16'hFFFE)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_opcode(opcode2),
    .o_busy(busy2), .o_done(done2), .o_illegal(illegal2),
    .i_pc(pc2), .o_pc_inc(pc_inc2),
    .o_rr_sel(rr_sel2), .i_rr_data(16'h0000), .o_rr_wr_en(rr_wr_en2), .o_rr_wr_data(rr_wr_data2),
    .o_sp(sp2), .o_mem_rd_addr(mem_rd_addr2), .i_mem_rd_data(mem_rd_data2),
    .o_mem_wr_en(mem_wr_en2), .o_mem_wr_addr(mem_wr_addr2), .o_mem_wr_data(mem_wr_data2),
    .o_dbg(dbg2)
  );

  assign rr_rd_data   = rf[rr_sel];
  assign mem_rd_data  = mem[mem_rd_addr];
  assign mem_rd_data2 = mem[mem_rd_addr2];

  // Environment: memory, register file and PC respond to DUT strobes; ld_* preloads them.
  always @(posedge clk) begin
    if (ld_mem) mem[ld_addr] <= ld_val[7:0];
    else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (ld_rf) rf[ld_addr[1:0]] <= ld_val;
    else if (rr_wr_en) rf[rr_sel] <= rr_wr_data;
    if (ld_pc) begin
      pc  <= ld_val;
      pc2 <= ld_val;
    end else begin
      if (pc_inc)  pc  <= pc + 16'd1;
      if (pc_inc2) pc2 <= pc2 + 16'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_mem(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({2'd1, a, 8'h00, d});
  endtask

  task automatic exp_rr(input logic [1:0] sel, input logic [15:0] d);
    exp_q.push_back({2'd2, 14'd0, sel, d});
  endtask

  task automatic sb_pop(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    if (exp_q.size() == 0) e = {W{1'b1}};
    else e = exp_q.pop_front();
    check(tag, 64'(obs), 64'(e));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en) sb_pop("mem_write", {2'd1, mem_wr_addr, 8'h00, mem_wr_data});
      if (rr_wr_en)  sb_pop("pair_write", {2'd2, 14'd0, rr_sel, rr_wr_data});
    end
  end

  task automatic poke(input int kind, input logic [15:0] a, input logic [15:0] v);
    ld_mem = (kind == 0);
    ld_rf = (kind == 1);
    ld_pc = (kind == 2);
    ld_addr = a;
    ld_val = v;
    @(posedge clk);
    #1;
    ld_mem = 1'b0;
    ld_rf = 1'b0;
    ld_pc = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge inside the o_done cycle.
  task automatic run_op(input logic [7:0] op, input int n_m, input logic [1:0] exp_sel,
                        input logic exp_ill, input bit spurious);
    int lat;
    bit busy_ok;
    bit sel_ok;
    lat = -1;
    busy_ok = 1'b1;
    sel_ok = 1'b1;
    start = 1'b1;
    opcode = op;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (rr_sel !== exp_sel) sel_ok = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (spurious && n == 2) begin
        start = 1'b1;
        opcode = 8'h00;
      end
      if (spurious && n == 3) start = 1'b0;
    end
    check("done_latency", 64'(lat), 64'(1 + n_m * T));
    check("busy_during_seq", busy_ok, 1'b1);
    check("busy_low_at_done", busy, 1'b0);
    check("illegal_flag", illegal, exp_ill);
    check("rr_sel_held", sel_ok, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat2;
    bit wr2_ok;
    bit seen;
    bit quiet;
    rst = 1'b1;
    start = 1'b0;
    opcode = 8'h00;
    start2 = 1'b0;
    opcode2 = 8'h00;
    ld_mem = 1'b0;
    ld_rf = 1'b0;
    ld_pc = 1'b0;
    ld_addr = '0;
    ld_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", {busy, done, illegal, pc_inc, rr_wr_en, mem_wr_en, rr_sel}, '0);
    check("reset_sp", sp, 16'hFFFE);
    check("reset_buses", {rr_wr_data, mem_rd_addr, mem_wr_addr, mem_wr_data}, '0);
    check("reset_state", dbg.state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // LD BC,d16
    poke(2, 16'h0000, 16'h0150);
    poke(0, 16'h0150, 16'h0034);
    poke(0, 16'h0151, 16'h0012);
    exp_rr(2'd0, 16'h1234);
    run_op(8'h01, 2, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("ld_bc_pc", pc, 16'h0152);
    check("ld_bc_sb_drained", exp_q.size(), 0);

    // Same load on the two-T-state instance
    lat2 = -1;
    wr2_ok = 1'b0;
    start2 = 1'b1;
    opcode2 = 8'h01;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done2 === 1'b1) begin
        lat2 = n;
        wr2_ok = (rr_wr_en2 === 1'b1) && (rr_wr_data2 === 16'h1234) && (rr_sel2 === 2'd0);
        break;
      end
    end
    check("t2_done_latency", 64'(lat2), 64'd5);
    check("t2_pair_write", wr2_ok, 1'b1);
    @(negedge clk);
    check("t2_pc", pc2, 16'h0152);

    // PUSH DE
    poke(1, 16'h0001, 16'hBEEF);
    exp_mem(16'hFFFD, 8'hBE);
    exp_mem(16'hFFFC, 8'hEF);
    run_op(8'hD5, 3, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("push_sp", sp, 16'hFFFC);
    check("push_sb_drained", exp_q.size(), 0);

    // POP AF with low flag nibble forced to zero
    poke(0, 16'hFFFC, 16'h00FF);
    poke(0, 16'hFFFD, 16'h0012);
    exp_rr(2'd3, 16'h12F0);
    run_op(8'hF1, 2, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("pop_sp", sp, 16'hFFFE);
    check("pop_sb_drained", exp_q.size(), 0);

    // LD SP,d16 then LD (FFFF),SP wrapping to 0000
    poke(2, 16'h0000, 16'h0200);
    poke(0, 16'h0200, 16'h00CD);
    poke(0, 16'h0201, 16'h00AB);
    poke(0, 16'h0202, 16'h00FF);
    poke(0, 16'h0203, 16'h00FF);
    run_op(8'h31, 2, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("ld_sp_imm", sp, 16'hABCD);
    exp_mem(16'hFFFF, 8'hCD);
    exp_mem(16'h0000, 8'hAB);
    run_op(8'h08, 4, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("ld_a16_sp_sp", sp, 16'hABCD);
    check("ld_a16_sp_pc", pc, 16'h0204);
    check("ld_a16_sb_drained", exp_q.size(), 0);

    // Start while busy ignored; back-to-back illegal then LD SP,HL
    poke(2, 16'h0000, 16'h0300);
    poke(0, 16'h0300, 16'h0078);
    poke(0, 16'h0301, 16'h0056);
    poke(1, 16'h0002, 16'hC0DE);
    exp_rr(2'd1, 16'h5678);
    run_op(8'h11, 2, 2'd1, 1'b0, 1'b1);
    run_op(8'h00, 0, 2'd0, 1'b1, 1'b0);
    check("illegal_sp_kept", sp, 16'hABCD);
    check("illegal_pc_kept", pc, 16'h0302);
    run_op(8'hF9, 1, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("ld_sp_hl", sp, 16'hC0DE);
    check("chain_sb_drained", exp_q.size(), 0);
    check("chain_idle", {busy, done, rr_sel}, '0);

    // Reset in the middle of PUSH BC, right after the first write
    poke(1, 16'h0000, 16'h1357);
    exp_mem(16'hC0DD, 8'h13);
    seen = 1'b0;
    start = 1'b1;
    opcode = 8'hC5;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mem_wr_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("push_first_write_seen", seen, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_strobes", {busy, done, illegal, pc_inc, rr_wr_en, mem_wr_en, rr_sel}, '0);
    check("abort_sp", sp, 16'hFFFE);
    check("abort_buses", {rr_wr_data, mem_rd_addr, mem_wr_addr, mem_wr_data}, '0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (mem_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
    end
    check("abort_quiet", quiet, 1'b1);
    check("abort_sb_drained", exp_q.size(), 0);
    check("abort_sp_after", sp, 16'hFFFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
